// File: rtl/mem_array_be.sv
// mem_array_be: single-port flop array with per-byte write enables,
// registered read with a valid strobe, and a hardware clear sweep.
module mem_array_be #(
   parameter int DW = 16,
   parameter int DEPTH = 8,
   parameter int AW = 3,
   localparam int NB = DW / 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cs,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] din,
   input  logic [NB-1:0] be,
   output logic [DW-1:0] dout,
   output logic          rd_valid,
   input  logic          clr,
   output logic          busy
);
   typedef enum logic {IDLE, CLEAR} state_t;
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
   state_t state, state_n;
   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] cnt;
   logic acc, hit;
   // clr wins over an access issued in the same IDLE cycle
   always_comb begin
      acc = state == IDLE && cs && !clr;
      hit = {1'b0, addr} < DEPTH_W;
      state_n = state == IDLE ? (clr ? CLEAR : IDLE) : (cnt == LAST ? IDLE : CLEAR);
   end
   assign busy = state == CLEAR;
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         dout <= '0;
         rd_valid <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         state <= state_n;
         rd_valid <= acc && !we;
         if (acc && !we) dout <= hit ? mem[addr] : '0;
         if (busy) begin
            mem[cnt] <= '0;
            cnt <= cnt == LAST ? '0 : cnt + 1'b1;
         end
         if (acc && we && hit)
            for (int i = 0; i < NB; i++)
               if (be[i]) mem[addr][8*i +: 8] <= din[8*i +: 8];
      end
endmodule

// File: tb/tb_mem_array_be.sv
// tb_mem_array_be: scoreboard bench for the default 16x8 array and a 32x5 variant.
module tb_mem_array_be;
   typedef struct {logic [31:0] d; int due;} exp_t;
   logic clk = 0, rst = 1;
   logic cs0 = 0, we0 = 0, clr0 = 0;
   logic [2:0] addr0 = 0;
   logic [15:0] din0 = 0, dout0;
   logic [1:0] be0 = 0;
   logic rd_valid0, busy0;
   logic cs1 = 0, we1 = 0, clr1 = 0;
   logic [2:0] addr1 = 0;
   logic [31:0] din1 = 0, dout1;
   logic [3:0] be1 = 0;
   logic rd_valid1, busy1;
   logic [15:0] m0 [8];
   exp_t q0[$], q1[$];
   int edge_cnt = 0, total = 0, bad = 0;

   mem_array_be u0 (.clk(clk), .rst(rst), .cs(cs0), .we(we0), .addr(addr0), .din(din0), .be(be0),
                    .dout(dout0), .rd_valid(rd_valid0), .clr(clr0), .busy(busy0));
   mem_array_be #(.DW(32), .DEPTH(5), .AW(3)) u1 (.clk(clk), .rst(rst), .cs(cs1), .we(we1), .addr(addr1),
                    .din(din1), .be(be1), .dout(dout1), .rd_valid(rd_valid1), .clr(clr1), .busy(busy1));

   always #5 clk = ~clk;

   // every cycle: a due read must show rd_valid with the queued data, otherwise rd_valid must be low
   always @(posedge clk) begin
      exp_t e;
      edge_cnt++;
      #1;
      total += 2;
      if (q0.size() > 0 && q0[0].due == edge_cnt) begin
         e = q0.pop_front();
         if (rd_valid0 !== 1'b1 || dout0 !== e.d[15:0]) begin
            bad++;
            $display("FAIL rd0 t=%0t got valid=%b dout=%h want valid=1 dout=%h", $time, rd_valid0, dout0, e.d[15:0]);
         end
      end else if (rd_valid0 !== 1'b0) begin
         bad++;
         $display("FAIL rd_valid0 t=%0t got=%b want=0", $time, rd_valid0);
      end
      if (q1.size() > 0 && q1[0].due == edge_cnt) begin
         e = q1.pop_front();
         if (rd_valid1 !== 1'b1 || dout1 !== e.d) begin
            bad++;
            $display("FAIL rd1 t=%0t got valid=%b dout=%h want valid=1 dout=%h", $time, rd_valid1, dout1, e.d);
         end
      end else if (rd_valid1 !== 1'b0) begin
         bad++;
         $display("FAIL rd_valid1 t=%0t got=%b want=0", $time, rd_valid1);
      end
   end

   task automatic wr0(input logic [2:0] a, input logic [15:0] d, input logic [1:0] b);
      @(negedge clk);
      cs0 = 1; we0 = 1; clr0 = 0; addr0 = a; din0 = d; be0 = b;
      for (int i = 0; i < 2; i++) if (b[i]) m0[a][8*i +: 8] = d[8*i +: 8];
   endtask

   task automatic rd0(input logic [2:0] a, input logic [15:0] e);
      @(negedge clk);
      cs0 = 1; we0 = 0; clr0 = 0; addr0 = a; be0 = 2'b11;
      q0.push_back('{32'(e), edge_cnt + 1});
   endtask

   task automatic idle0();
      @(negedge clk);
      cs0 = 0; we0 = 0; clr0 = 0;
   endtask

   task automatic wr1(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
      @(negedge clk);
      cs1 = 1; we1 = 1; clr1 = 0; addr1 = a; din1 = d; be1 = b;
   endtask

   task automatic rd1(input logic [2:0] a, input logic [31:0] e);
      @(negedge clk);
      cs1 = 1; we1 = 0; clr1 = 0; addr1 = a; be1 = 4'b0000;
      q1.push_back('{e, edge_cnt + 1});
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1; cs0 = 1; we0 = 1; addr0 = 1; din0 = 16'hFFFF; be0 = 2'b11;
      repeat (2) @(negedge clk);
      total += 5;
      if (dout0 !== 16'h0) begin bad++; $display("FAIL reset_dout0 got=%h want=0000", dout0); end
      if (rd_valid0 !== 1'b0) begin bad++; $display("FAIL reset_rd_valid0 got=%b want=0", rd_valid0); end
      if (busy0 !== 1'b0) begin bad++; $display("FAIL reset_busy0 got=%b want=0", busy0); end
      if (dout1 !== 32'h0) begin bad++; $display("FAIL reset_dout1 got=%h want=0", dout1); end
      if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy1 got=%b want=0", busy1); end
      rst = 0; cs0 = 0;
      for (int k = 0; k < 8; k++) m0[k] = 16'h0;
      for (int k = 0; k < 8; k++) rd0(3'(k), 16'h0000);
      idle0();
   endtask

   task automatic test_write_read();
      wr0(3, 16'hA5C3, 2'b11);
      rd0(3, 16'hA5C3);
      idle0();
      idle0();
      total++;
      if (dout0 !== 16'hA5C3) begin bad++; $display("FAIL dout_hold got=%h want=a5c3", dout0); end
   endtask

   task automatic test_byte_enable();
      wr0(3, 16'h1234, 2'b01);
      rd0(3, 16'hA534);
      wr0(3, 16'hFFFF, 2'b00);
      rd0(3, 16'hA534);
      wr0(3, 16'h7700, 2'b10);
      rd0(3, 16'h7734);
      idle0();
   endtask

   task automatic test_clear();
      int nb = 0;
      for (int k = 0; k < 8; k++) wr0(3'(k), 16'(16'h1111 * (k + 1)), 2'b11);
      rd0(7, 16'h8888);
      @(negedge clk);
      cs0 = 0; clr0 = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy0) begin
            nb++;
            total++;
            if (dout0 !== 16'h8888) begin bad++; $display("FAIL clear_dout_hold got=%h want=8888", dout0); end
            cs0 = 1; we0 = i[0]; addr0 = 0; din0 = 16'hBEEF; be0 = 2'b11; clr0 = (i == 2);
         end else begin
            cs0 = 0; clr0 = 0;
         end
      end
      total += 2;
      if (nb !== 8) begin bad++; $display("FAIL busy_cycles got=%0d want=8", nb); end
      if (dout0 !== 16'h8888) begin bad++; $display("FAIL post_clear_dout got=%h want=8888", dout0); end
      for (int k = 0; k < 8; k++) m0[k] = 16'h0;
      for (int k = 0; k < 8; k++) rd0(3'(k), 16'h0000);
      idle0();
   endtask

   task automatic test_clr_priority();
      wr0(2, 16'h5555, 2'b11);
      wr0(6, 16'h6666, 2'b11);
      wr0(7, 16'h7777, 2'b11);
      @(negedge clk);
      cs0 = 1; we0 = 0; addr0 = 2; clr0 = 1;
      @(negedge clk);
      cs0 = 0; clr0 = 0;
      total++;
      if (busy0 !== 1'b1) begin bad++; $display("FAIL sweep_start_busy got=%b want=1", busy0); end
      repeat (3) @(negedge clk);
      total++;
      if (busy0 !== 1'b1) begin bad++; $display("FAIL sweep_cycle4_busy got=%b want=1", busy0); end
      rst = 1;
      @(negedge clk);
      rst = 0;
      total += 2;
      if (busy0 !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy0); end
      if (dout0 !== 16'h0) begin bad++; $display("FAIL abort_dout got=%h want=0000", dout0); end
      for (int k = 0; k < 8; k++) m0[k] = 16'h0;
      for (int k = 0; k < 8; k++) rd0(3'(k), 16'h0000);
      idle0();
   endtask

   task automatic test_back_to_back();
      logic [2:0] a;
      logic [15:0] d;
      logic [1:0] b;
      for (int i = 0; i < 60; i++) begin
         a = 3'($urandom_range(0, 7));
         d = 16'($urandom);
         b = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 2))
            0: wr0(a, d, b);
            1: rd0(a, m0[a]);
            default: idle0();
         endcase
      end
      idle0();
   endtask

   task automatic test_wide();
      wr1(4, 32'hDEADBEEF, 4'b1010);
      rd1(4, 32'hDE00BE00);
      wr1(6, 32'hFFFFFFFF, 4'b1111);
      rd1(6, 32'h0);
      rd1(4, 32'hDE00BE00);
      rd1(5, 32'h0);
      rd1(0, 32'h0);
      @(negedge clk);
      cs1 = 0;
      idle0();
      total++;
      if (dout1 !== 32'h0) begin bad++; $display("FAIL wide_dout_hold got=%h want=0", dout1); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byte_enable();
      test_clear();
      test_clr_priority();
      test_back_to_back();
      test_wide();
      repeat (3) @(negedge clk);
      total++;
      if (q0.size() + q1.size() !== 0) begin bad++; $display("FAIL pending_reads got=%0d want=0", q0.size() + q1.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
